// File: rtl/cv32e41p_instr_aligner.sv
// Instruction aligner: turns word-aligned fetch words into 32-bit / RVC
// instructions, keeps a residual half-word and the PC of the instruction
// being presented to ID.
module cv32e41p_instr_aligner #(
  parameter bit PULP_XPULP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] boot_addr_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_ready_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_aligned_o,
  output logic        instr_compressed_o,
  output logic [31:0] pc_o,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        hwlp_jump_i,
  input  logic [31:0] hwlp_target_i
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned HLEN = 16;

  typedef enum logic [1:0] {
    ALIGNED    = 2'd0,
    MISALIGNED = 2'd1,
    BRANCH_MIS = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [HLEN-1:0]   r_h;
  logic [HLEN-1:0]   w_h_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   w_pc_nxt;

  logic              w_hwlp;
  logic              w_redirect;
  logic [XLEN-1:0]   w_target;
  logic              w_live;
  logic              w_valid_raw;
  logic              w_pop_on_accept;
  logic              w_silent_pop;
  logic              w_comp;
  logic              w_accept;
  logic [HLEN-1:0]   w_lo;
  logic [HLEN-1:0]   w_hi;

  assign w_lo = fetch_rdata_i[HLEN-1:0];
  assign w_hi = fetch_rdata_i[XLEN-1:HLEN];

  // Redirect selection: branch beats hardware loop, hwlp only when enabled
  assign w_hwlp     = PULP_XPULP & hwlp_jump_i;
  assign w_redirect = branch_i | w_hwlp;
  assign w_target   = branch_i ? branch_addr_i : hwlp_target_i;
  // Handshakes are only live out of reset and outside a redirect cycle
  assign w_live     = rst_n & ~w_redirect;

  // State register with synchronous reset; residual and PC travel with it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ALIGNED;
      r_h     <= '0;
      r_pc    <= {boot_addr_i[XLEN-1:2], 2'b00};
    end else begin
      r_state <= w_state_nxt;
      r_h     <= w_h_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Output decode: instruction assembly and handshake terms per state
  always_comb begin
    w_valid_raw     = 1'b0;
    w_pop_on_accept = 1'b0;
    w_silent_pop    = 1'b0;
    w_comp          = 1'b0;
    instr_aligned_o = fetch_rdata_i;
    unique case (r_state)
      ALIGNED: begin
        w_valid_raw     = fetch_valid_i;
        w_pop_on_accept = 1'b1;
        if (w_lo[1:0] != 2'b11) begin
          instr_aligned_o = {16'h0000, w_lo};
          w_comp          = 1'b1;
        end
      end
      MISALIGNED: begin
        if (r_h[1:0] != 2'b11) begin
          // Residual alone is a full RVC instruction, no fetch word needed
          w_valid_raw     = 1'b1;
          instr_aligned_o = {16'h0000, r_h};
          w_comp          = 1'b1;
        end else begin
          w_valid_raw     = fetch_valid_i;
          w_pop_on_accept = 1'b1;
          instr_aligned_o = {w_lo, r_h};
        end
      end
      BRANCH_MIS: begin
        if (w_hi[1:0] != 2'b11) begin
          w_valid_raw     = fetch_valid_i;
          w_pop_on_accept = 1'b1;
          instr_aligned_o = {16'h0000, w_hi};
          w_comp          = 1'b1;
        end else begin
          // Upper half starts a 32-bit instruction: drop the word into r_h
          w_silent_pop = fetch_valid_i;
        end
      end
      default: begin
        w_valid_raw = 1'b0;
      end
    endcase
    w_accept           = w_live & w_valid_raw & instr_ready_i;
    instr_valid_o      = w_live & w_valid_raw;
    instr_compressed_o = w_comp;
    fetch_ready_o      = (w_accept & w_pop_on_accept) | (w_live & w_silent_pop);
    pc_o               = r_pc;
  end

  // Next-state: redirect first, otherwise advance on accept / silent pop
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h;
    w_pc_nxt    = r_pc;
    if (w_redirect) begin
      w_pc_nxt    = w_target;
      w_h_nxt     = '0;
      w_state_nxt = w_target[1] ? BRANCH_MIS : ALIGNED;
    end else begin
      unique case (r_state)
        ALIGNED: begin
          if (w_accept) begin
            if (w_comp) begin
              w_h_nxt     = w_hi;
              w_state_nxt = MISALIGNED;
              w_pc_nxt    = r_pc + 32'd2;
            end else begin
              w_pc_nxt    = r_pc + 32'd4;
            end
          end
        end
        MISALIGNED: begin
          if (w_accept) begin
            if (w_comp) begin
              w_state_nxt = ALIGNED;
              w_pc_nxt    = r_pc + 32'd2;
            end else begin
              w_h_nxt     = w_hi;
              w_pc_nxt    = r_pc + 32'd4;
            end
          end
        end
        BRANCH_MIS: begin
          if (w_accept) begin
            w_state_nxt = ALIGNED;
            w_pc_nxt    = r_pc + 32'd2;
          end else if (w_silent_pop) begin
            w_h_nxt     = w_hi;
            w_state_nxt = MISALIGNED;
          end
        end
        default: begin
          w_state_nxt = ALIGNED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e41p_instr_aligner.sv
// Bench for the instruction aligner: two instances (hwlp enabled/disabled)
// on shared stimulus, checked against a half-word stream reference model.
module tb_cv32e41p_instr_aligner;

  logic        clk;
  logic        rst_n;
  logic [31:0] boot_addr_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        instr_ready_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        hwlp_jump_i;
  logic [31:0] hwlp_target_i;

  logic        fr [2];
  logic        iv [2];
  logic [31:0] ia [2];
  logic        ic [2];
  logic [31:0] pc [2];

  int n_checks;
  int n_errors;

  // Reference model state: PC, buffered half-words, pending lower-half skip
  logic [31:0] m_pc  [2];
  int          m_cnt [2];
  logic [15:0] m_qv  [2];
  logic        m_skip[2];

  cv32e41p_instr_aligner #(.PULP_XPULP(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .boot_addr_i(boot_addr_i),
    .fetch_valid_i(fetch_valid_i), .fetch_rdata_i(fetch_rdata_i),
    .fetch_ready_o(fr[0]), .instr_valid_o(iv[0]), .instr_ready_i(instr_ready_i),
    .instr_aligned_o(ia[0]), .instr_compressed_o(ic[0]), .pc_o(pc[0]),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .hwlp_jump_i(hwlp_jump_i), .hwlp_target_i(hwlp_target_i)
  );

  cv32e41p_instr_aligner #(.PULP_XPULP(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .boot_addr_i(boot_addr_i),
    .fetch_valid_i(fetch_valid_i), .fetch_rdata_i(fetch_rdata_i),
    .fetch_ready_o(fr[1]), .instr_valid_o(iv[1]), .instr_ready_i(instr_ready_i),
    .instr_aligned_o(ia[1]), .instr_compressed_o(ic[1]), .pc_o(pc[1]),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .hwlp_jump_i(hwlp_jump_i), .hwlp_target_i(hwlp_target_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Model: instruction = head of (buffered half-words ++ usable fetch halves)
  task automatic model_step(input int k);
    logic [15:0] s [4];
    int          n;
    int          nq;
    int          need;
    logic        redir;
    logic        cmpl;
    logic        acc;
    logic        pop;
    logic [31:0] tgt;
    logic [31:0] ei;
    redir = branch_i || (k == 0 && hwlp_jump_i);
    tgt   = branch_i ? branch_addr_i : hwlp_target_i;
    for (int i = 0; i < 4; i++) s[i] = 16'h0;
    if (!rst_n) begin
      chk("rst_valid", k, 32'(iv[k]), 32'd0);
      chk("rst_ready", k, 32'(fr[k]), 32'd0);
      m_pc[k]   = {boot_addr_i[31:2], 2'b00};
      m_cnt[k]  = 0;
      m_skip[k] = 1'b0;
    end else begin
      chk("pc", k, pc[k], m_pc[k]);
      if (redir) begin
        chk("redir_valid", k, 32'(iv[k]), 32'd0);
        chk("redir_ready", k, 32'(fr[k]), 32'd0);
        m_pc[k]   = tgt;
        m_cnt[k]  = 0;
        m_skip[k] = tgt[1];
      end else begin
        n = 0;
        if (m_cnt[k] > 0) begin
          s[n] = m_qv[k];
          n++;
        end
        nq = n;
        if (fetch_valid_i) begin
          if (!m_skip[k]) begin
            s[n] = fetch_rdata_i[15:0];
            n++;
          end
          s[n] = fetch_rdata_i[31:16];
          n++;
        end
        need = (n > 0 && s[0][1:0] == 2'b11) ? 2 : 1;
        cmpl = (n >= need);
        chk("valid", k, 32'(iv[k]), 32'(cmpl));
        if (cmpl) begin
          ei = (need == 1) ? {16'h0, s[0]} : {s[1], s[0]};
          chk("instr", k, ia[k], ei);
          chk("compressed", k, 32'(ic[k]), 32'(need == 1));
        end
        acc = cmpl && instr_ready_i;
        pop = fetch_valid_i && (acc ? (need > nq) : !cmpl);
        chk("ready", k, 32'(fr[k]), 32'(pop));
        if (acc) begin
          m_pc[k] = m_pc[k] + 32'(need * 2);
          if (pop) begin
            m_cnt[k] = n - need;
            if (n > need) m_qv[k] = s[need];
            m_skip[k] = 1'b0;
          end else begin
            m_cnt[k] = nq - need;
          end
        end else if (pop) begin
          m_cnt[k]  = n;
          m_qv[k]   = s[n-1];
          m_skip[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic sample();
    #1;
    model_step(0);
    model_step(1);
  endtask

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] t);
    fetch_valid_i = 1'b0;
    branch_i      = 1'b1;
    branch_addr_i = t;
    sample();
    adv();
    branch_i      = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_cnt[k] = 0; m_qv[k] = 16'h0; m_skip[k] = 1'b0;
    end
    rst_n = 1'b0; boot_addr_i = 32'h0000_0082;
    fetch_valid_i = 1'b0; fetch_rdata_i = 32'h0; instr_ready_i = 1'b1;
    branch_i = 1'b0; branch_addr_i = 32'h0; hwlp_jump_i = 1'b0; hwlp_target_i = 32'h0;
    @(negedge clk);
    sample(); adv();
    sample(); chk("boot_pc", 0, pc[0], 32'h0000_0080); adv();

    // Two 32-bit instructions from boot
    rst_n = 1'b1; fetch_valid_i = 1'b1; fetch_rdata_i = 32'h00A0_0513;
    sample();
    chk("t1_instr0", 0, ia[0], 32'h00A0_0513);
    chk("t1_pop0", 0, 32'(fr[0]), 32'd1);
    adv();
    fetch_rdata_i = 32'h0000_0013;
    sample();
    chk("t1_pc1", 0, pc[0], 32'h0000_0084);
    adv();

    // Two RVC in one word, second issued without a fetch word
    redirect(32'h0000_0100);
    fetch_valid_i = 1'b1; fetch_rdata_i = 32'h4501_4505;
    sample(); chk("t2_instr0", 0, ia[0], 32'h0000_4505); adv();
    fetch_valid_i = 1'b0;
    sample();
    chk("t2_instr1", 0, ia[0], 32'h0000_4501);
    chk("t2_pc1", 0, pc[0], 32'h0000_0102);
    chk("t2_nopop", 0, 32'(fr[0]), 32'd0);
    adv();
    sample(); chk("t2_pc2", 0, pc[0], 32'h0000_0104); adv();

    // RVC then a 32-bit instruction straddling two words
    redirect(32'h0000_0100);
    fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0513_4505;
    sample(); adv();
    fetch_rdata_i = 32'h1234_00A0;
    sample();
    chk("t3_instr", 0, ia[0], 32'h00A0_0513);
    chk("t3_pc", 0, pc[0], 32'h0000_0102);
    adv();
    fetch_valid_i = 1'b0; instr_ready_i = 1'b0;
    sample();
    chk("t3_resid", 0, ia[0], 32'h0000_1234);
    chk("t3_pc2", 0, pc[0], 32'h0000_0106);
    adv();
    instr_ready_i = 1'b1;

    // Half-word branch targets: RVC in upper half, then silent pop path
    redirect(32'h0000_0202);
    fetch_valid_i = 1'b1; fetch_rdata_i = 32'h4585_1111;
    sample();
    chk("t4_instr", 0, ia[0], 32'h0000_4585);
    chk("t4_pc", 0, pc[0], 32'h0000_0202);
    adv();
    redirect(32'h0000_0302);
    fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0513_2222;
    sample(); chk("t4_silent", 0, 32'(fr[0]), 32'd1); adv();
    fetch_rdata_i = 32'hFFFF_00A0;
    sample();
    chk("t4_instr2", 0, ia[0], 32'h00A0_0513);
    chk("t4_pc2", 0, pc[0], 32'h0000_0302);
    adv();

    // Branch and hwlp together; then a lone hwlp on both variants
    fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0000_0013;
    branch_i = 1'b1; branch_addr_i = 32'h0000_0400;
    hwlp_jump_i = 1'b1; hwlp_target_i = 32'h0000_0500;
    sample(); adv();
    branch_i = 1'b0; hwlp_jump_i = 1'b0; fetch_valid_i = 1'b0;
    sample(); chk("t5_pc0", 0, pc[0], 32'h0000_0400); chk("t5_pc1", 1, pc[1], 32'h0000_0400); adv();
    hwlp_jump_i = 1'b1;
    sample(); adv();
    hwlp_jump_i = 1'b0;
    sample(); chk("t5_hw0", 0, pc[0], 32'h0000_0500); chk("t5_hw1", 1, pc[1], 32'h0000_0400); adv();

    // Reset while holding a residual
    redirect(32'h0000_0100);
    fetch_valid_i = 1'b1; fetch_rdata_i = 32'h4501_4505;
    sample(); adv();
    rst_n = 1'b0; fetch_valid_i = 1'b0;
    sample(); adv();
    rst_n = 1'b1;
    sample();
    chk("t6_valid", 0, 32'(iv[0]), 32'd0);
    chk("t6_pc", 0, pc[0], 32'h0000_0080);
    adv();
    fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0000_0013;
    sample(); chk("t6_instr", 0, ia[0], 32'h0000_0013); adv();

    // PC wrap-around
    redirect(32'hFFFF_FFFE);
    fetch_valid_i = 1'b1; fetch_rdata_i = 32'h4501_0000;
    sample(); chk("t7_instr", 0, ia[0], 32'h0000_4501); adv();
    fetch_valid_i = 1'b0;
    sample(); chk("t7_wrap", 0, pc[0], 32'h0000_0000); adv();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n         = ($urandom_range(0, 199) != 0);
      boot_addr_i   = $urandom;
      fetch_valid_i = ($urandom_range(0, 3) != 0);
      if (fr[0] || $urandom_range(0, 2) == 0) fetch_rdata_i = $urandom;
      instr_ready_i = ($urandom_range(0, 3) != 0);
      branch_i      = ($urandom_range(0, 11) == 0);
      branch_addr_i = $urandom & 32'hFFFF_FFFE;
      hwlp_jump_i   = ($urandom_range(0, 11) == 0);
      hwlp_target_i = $urandom & 32'hFFFF_FFFE;
      sample();
      adv();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
